// File: rtl/instruction_fetch_decode_pkg.sv
// Shared types and constants for the LUMOS RV32I fetch stage and control unit.
// Contents: instruction format codes, RV32I opcode constants, fetch FSM states,
//           and a word-alignment helper.
package instruction_fetch_decode_pkg;

  // Instruction format codes seen by the immediate generator.
  typedef enum logic [2:0] {
    R_TYPE    = 3'd0,
    I_TYPE    = 3'd1,
    S_TYPE    = 3'd2,
    B_TYPE    = 3'd3,
    U_TYPE    = 3'd4,
    J_TYPE    = 3'd5,
    NONE_TYPE = 3'd7
  } instr_type_e;

  // Fetch FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  // RV32I major opcodes (instruction[6:0]).
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;

  // Clear the byte-offset bits of an address.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instruction_fetch_decode_opcode_type_decoder.sv
// Purpose: combinational map from RV32I opcode to instruction format code.
// Latency: 0 cycles (pure combinational).  Backpressure: none, no state.
// Ports: opcode in; instr_type out. With LUMOS_ILLEGAL_INSTR_EN defined, also
//        funct3 in and illegal out (unknown opcode, non-32-bit encoding, or
//        JALR with non-zero funct3).
module opcode_type_decoder
  import instruction_fetch_decode_pkg::*;
(
  input  logic [6:0]  opcode,
`ifdef LUMOS_ILLEGAL_INSTR_EN
  input  logic [2:0]  funct3,
  output logic        illegal,
`endif
  output instr_type_e instr_type
);

  always_comb begin
    instr_type = NONE_TYPE;
    case (opcode)
      OPC_LUI, OPC_AUIPC:                 instr_type = U_TYPE;
      OPC_JAL:                            instr_type = J_TYPE;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM,
      OPC_MISC_MEM, OPC_SYSTEM:           instr_type = I_TYPE;
      OPC_STORE:                          instr_type = S_TYPE;
      OPC_BRANCH:                         instr_type = B_TYPE;
      OPC_OP:                             instr_type = R_TYPE;
      default:                            instr_type = NONE_TYPE;
    endcase
  end

`ifdef LUMOS_ILLEGAL_INSTR_EN
  // Every known opcode already ends in 2'b11; the explicit length test keeps
  // the intent readable if the opcode list ever grows.
  assign illegal = (instr_type == NONE_TYPE) ||
                   (opcode[1:0] != 2'b11) ||
                   ((opcode == OPC_JALR) && (funct3 != 3'b000));
`endif

endmodule

// File: rtl/instruction_fetch_decode.sv
// Purpose: multicycle RV32I fetch stage; owns the PC, reads instruction memory, latches and decodes the word.
// Latency: instruction_valid rises the cycle after mem_ready; at best one instruction every 2 cycles.
// Backpressure: HOLD keeps all outputs stable until instruction_ready; the memory request is held until mem_ready.
// Ports: clk/reset (async active-low); fetch_enable; mem_req/mem_addr/mem_ready/mem_rdata;
//        redirect_valid/redirect_pc; instruction_valid/instruction_ready/instruction/
//        instruction_type/instruction_pc. Optional macro LUMOS_ILLEGAL_INSTR_EN adds illegal_instruction.
module instruction_fetch_decode
  import instruction_fetch_decode_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_enable,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instruction_valid,
  input  logic        instruction_ready,
  output logic [31:0] instruction,
  output logic [2:0]  instruction_type,
`ifdef LUMOS_ILLEGAL_INSTR_EN
  output logic        illegal_instruction,
`endif
  output logic [31:0] instruction_pc
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  logic         kill_q, kill_d;
  logic [31:0]  instr_q, instr_d;
  instr_type_e  type_q, type_d;
  logic [31:0]  ipc_q, ipc_d;
  logic [31:0]  redirect_tgt;
  instr_type_e  dec_type;
`ifdef LUMOS_ILLEGAL_INSTR_EN
  logic         illegal_q, illegal_d;
  logic         dec_illegal;
`endif

  assign redirect_tgt = word_align(redirect_pc);

  opcode_type_decoder u_decoder (
    .opcode     (mem_rdata[6:0]),
`ifdef LUMOS_ILLEGAL_INSTR_EN
    .funct3     (mem_rdata[14:12]),
    .illegal    (dec_illegal),
`endif
    .instr_type (dec_type)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    instr_d = instr_q;
    type_d  = type_q;
    ipc_d   = ipc_q;
`ifdef LUMOS_ILLEGAL_INSTR_EN
    illegal_d = illegal_q;
`endif

    case (state_q)
      IDLE: begin
        if (redirect_valid) pc_d = redirect_tgt;
        if (fetch_enable)   state_d = FETCH;
      end

      FETCH: begin
        if (mem_ready) begin
          if (kill_q || redirect_valid) begin
            // Response belongs to a stale path: drop it and refetch from pc.
            kill_d = 1'b0;
            if (redirect_valid) pc_d = redirect_tgt;
          end else begin
            instr_d = mem_rdata;
            type_d  = dec_type;
            ipc_d   = pc_q;
`ifdef LUMOS_ILLEGAL_INSTR_EN
            illegal_d = dec_illegal;
`endif
            state_d = HOLD;
          end
        end else if (redirect_valid) begin
          // Request cannot be withdrawn; remember to discard its response.
          kill_d = 1'b1;
          pc_d   = redirect_tgt;
        end
      end

      HOLD: begin
        // A redirect beats a same-cycle accept, so the held word is dropped
        // without advancing the PC.
        if (redirect_valid) begin
          pc_d    = redirect_tgt;
          state_d = FETCH;
        end else if (instruction_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = fetch_enable ? FETCH : IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // The address of an outstanding request is frozen until it completes;
    // otherwise it tracks the PC so the next request goes out from pc.
    addr_d = ((state_q == FETCH) && !mem_ready) ? addr_q : pc_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      kill_q  <= 1'b0;
      instr_q <= 32'h0;
      type_q  <= NONE_TYPE;
      ipc_q   <= RESET_PC;
`ifdef LUMOS_ILLEGAL_INSTR_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      kill_q  <= kill_d;
      instr_q <= instr_d;
      type_q  <= type_d;
      ipc_q   <= ipc_d;
`ifdef LUMOS_ILLEGAL_INSTR_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  assign mem_req           = (state_q == FETCH);
  assign mem_addr          = addr_q;
  assign instruction_valid = (state_q == HOLD);
  assign instruction       = instr_q;
  assign instruction_type  = type_q;
  assign instruction_pc    = ipc_q;
`ifdef LUMOS_ILLEGAL_INSTR_EN
  assign illegal_instruction = illegal_q;
`endif

endmodule

// File: doc/instruction_fetch_decode.md
Name: instruction_fetch_decode

Overview:
- Multicycle fetch stage of the LUMOS RV32I core, directly upstream of the immediate generator.
- Owns the fetch PC and issues word reads to instruction memory over a req/ready handshake.
- Latches the returned word into the instruction register and decodes its opcode into the 3-bit instruction_type.
- Presents instruction, instruction_type and its PC to the decode/immediate stages under a valid/ready handshake, and accepts control-flow redirects at any time.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 00.

Ports:
clk  in  1  core clock, rising edge.
reset  in  1  asynchronous, active-low reset.
fetch_enable  in  1  allows leaving IDLE and issuing new fetches.
mem_req  out  1  instruction-memory read request.
mem_addr  out  32  word-aligned read address.
mem_ready  in  1  memory completes the request this cycle.
mem_rdata  in  32  read data; valid when mem_req and mem_ready are both high.
redirect_valid  in  1  control-flow change request.
redirect_pc  in  32  target; bits [1:0] are ignored and forced to 00.
instruction_valid  out  1  instruction/type/instruction_pc are valid.
instruction_ready  in  1  downstream accepts the presented instruction.
instruction  out  32  latched instruction word.
instruction_type  out  3  decoded format, encoded per Defines.vh.
instruction_pc  out  32  address of the presented instruction.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; pc=RESET_PC; mem_req=0; mem_addr=RESET_PC; instruction_valid=0.
  - instruction=32'h0; instruction_type=NONE_TYPE; instruction_pc=RESET_PC; kill flag=0.
- States: IDLE, FETCH, HOLD.
- IDLE:
  - mem_req=0.
  - fetch_enable=1 -> FETCH next cycle, with mem_addr=pc.
- FETCH:
  - mem_req=1; mem_addr=pc, held stable until mem_ready.
  - mem_ready=1 and kill=0 -> latch instruction=mem_rdata, instruction_pc=pc and decoded type; go to HOLD.
  - Minimum latency: instruction_valid rises the cycle after mem_ready.
- HOLD:
  - instruction_valid=1; all outputs held stable.
  - On instruction_valid & instruction_ready: pc=pc+4 (modulo 2^32; wraps 32'hFFFF_FFFC -> 0).
  - After that handshake: go to FETCH if fetch_enable=1, else IDLE.
- Redirect, by state:
  - IDLE: pc=redirect_pc.
  - HOLD: drop the held instruction (instruction_valid=0 next cycle); pc=redirect_pc; go to FETCH. This wins over a same-cycle instruction_ready, so no pc+4 occurs.
  - FETCH with mem_ready=1 in the same cycle: discard the response; pc=redirect_pc; stay in FETCH, issuing the new address next cycle.
  - FETCH with mem_ready=0: set kill=1 and pc=redirect_pc. mem_addr keeps the old address until mem_ready, because the request cannot be withdrawn. When that response arrives it is discarded, kill clears, and the next cycle requests redirect_pc.
  - A further redirect while kill=1 only updates pc.
- fetch_enable deasserted during FETCH: the outstanding request still completes. Deassertion is checked only at the HOLD exit.
- Decode (opcode = instruction[6:0]):
  - 0110111, 0010111 -> U_TYPE.
  - 1101111 -> J_TYPE.
  - 1100111, 0000011, 0010011, 0001111, 1110011 -> I_TYPE.
  - 0100011 -> S_TYPE.
  - 1100011 -> B_TYPE.
  - 0110011 -> R_TYPE.
  - anything else -> NONE_TYPE.
- instruction_type is registered alongside instruction; there is no combinational path from mem_rdata to any output.

Optional Feature:
- Macro: LUMOS_ILLEGAL_INSTR_EN.
- Defined:
  - Adds output illegal_instruction (1 bit, reset 0), registered with instruction.
  - Set for NONE_TYPE opcodes, instruction[1:0]!=2'b11, and funct3!=000 on opcode 1100111.
  - Valid only while instruction_valid=1.
- Undefined: the port is absent; unknown opcodes are reported only as NONE_TYPE.

Decomposition:
- Defines.vh (shared) holds:
  - type codes R_TYPE=3'd0, I_TYPE=3'd1, S_TYPE=3'd2, B_TYPE=3'd3, U_TYPE=3'd4, J_TYPE=3'd5, NONE_TYPE=3'd7;
  - the RV32I opcode constants;
  - the FSM state encodings IDLE/FETCH/HOLD.
- Natural sub-module: opcode_type_decoder, a combinational map from opcode to type (plus the illegal flag when the macro is enabled), reused by the core's control unit.

Test Plan:
- Reset, fetch_enable=1, mem_ready=1 always, mem_rdata=32'h00500093 -> mem_addr=0; one cycle later instruction_valid=1, instruction_type=I_TYPE, instruction_pc=0. After the accept, mem_addr=4.
- Memory stalls 3 cycles returning 32'h00112623 -> mem_req and mem_addr stay constant 3 cycles; then type=S_TYPE. instruction_ready=0 for 2 cycles -> outputs held.
- Redirect to 32'h100 while FETCH is waiting at 0x8 -> mem_addr stays 0x8 until ready; that response is never made valid; the next request is at 0x100.
- Redirect 32'h203 in HOLD with instruction_ready=1 in the same cycle -> instruction dropped, next mem_addr=0x200, no pc+4.
- pc=32'hFFFF_FFFC accepted -> next mem_addr=0. mem_rdata=32'hFFFFFFFF -> NONE_TYPE; illegal_instruction=1 when LUMOS_ILLEGAL_INSTR_EN is defined.
- Assert reset low mid-FETCH -> mem_req=0 and instruction_valid=0 immediately; after release, fetch restarts at RESET_PC.
